mux_scan_ctrl: RTL

//  Upstream sequencer for the 4-in/1-out case multiplexer. Drives the mux select,

---
 rtl/mux_scan_ctrl_pkg.sv | 17 +
 rtl/mux_settle_cnt.sv | 38 +++
 rtl/mux_scan_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/mux_scan_ctrl_pkg.sv
// Shared types and constants for the 4:1 mux scan controller.
package mux_scan_ctrl_pkg;

  // Controller states; the encodings are fixed so they can be read on a debug bus.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSettle = 2'd1,
    StDone   = 2'd2
  } scan_state_e;

  // Number of mux inputs scanned per snapshot.
  localparam int unsigned NumCh = 4;

  // Select value of the last channel in a scan.
  localparam logic [1:0] LastCh = 2'd3;

endpackage

// File: rtl/mux_settle_cnt.sv
// Settle-time counter: synchronous clear, enable, wraps to zero on terminal count.
module mux_settle_cnt #(
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned CNT_W      = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam logic [CNT_W-1:0] TcVal = CNT_W'(SETTLE_CYC - 1);

  logic [CNT_W-1:0] count_q, count_d;

  // Clear wins over enable; the count returns to zero on the terminal cycle.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = (count_q == TcVal) ? '0 : count_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == TcVal);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan controller for a 4:1 mux: steps the select, waits a settle time per channel,
// gathers one bit per channel and hands the 4-bit snapshot over a valid/ack handshake.
module mux_scan_ctrl #(
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned CNT_W      = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cont,
  input  logic       mux_q,
  output logic [1:0] sel,
  output logic [3:0] snapshot,
  output logic       valid,
  input  logic       ack,
  output logic       busy
);

  import mux_scan_ctrl_pkg::*;

  scan_state_e      state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [NumCh-1:0] shadow_q, shadow_d;
  logic [NumCh-1:0] snapshot_q, snapshot_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             cnt_clr, cnt_en, cnt_tc;

  mux_settle_cnt #(
    .SETTLE_CYC (SETTLE_CYC),
    .CNT_W      (CNT_W)
  ) u_settle_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (cnt_clr),
    .enable (cnt_en),
    .tc     (cnt_tc)
  );

  // Next-state logic for the scan sequence and the output registers.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    shadow_d   = shadow_q;
    snapshot_d = snapshot_q;
    valid_d    = valid_q;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    unique case (state_q)
      StIdle: begin
        sel_d = '0;
        if (start) begin
          state_d = StSettle;
          cnt_clr = 1'b1;
        end
      end
      StSettle: begin
        cnt_en = 1'b1;
        if (cnt_tc) begin
          shadow_d[sel_q] = mux_q;
          if (sel_q != LastCh) begin
            sel_d = sel_q + 2'd1;
          end else begin
            // Last channel goes straight into the snapshot, not via the shadow.
            snapshot_d = {mux_q, shadow_q[2:0]};
            valid_d    = 1'b1;
            sel_d      = '0;
            state_d    = StDone;
          end
        end
      end
      StDone: begin
        if (valid_q && ack) begin
          valid_d = 1'b0;
          if (cont) begin
            state_d = StSettle;
            cnt_clr = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    busy_d = (state_d != StIdle);
  end

  // State and output registers; every output comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      sel_q      <= '0;
      shadow_q   <= '0;
      snapshot_q <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      shadow_q   <= shadow_d;
      snapshot_q <= snapshot_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
    end
  end

  assign sel      = sel_q;
  assign snapshot = snapshot_q;
  assign valid    = valid_q;
  assign busy     = busy_q;

endmodule
